// File: rtl/gpio_seq_master.sv
// AHB-Lite master that plays a pattern table into the GPIO peripheral: one DIR write,
// then an OUT write, an IN readback and a programmable hold for each pattern.
module gpio_seq_master #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_8000,
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter int          HOLD_W    = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic [31:0]       dir_value,
    input  logic [AW:0]       num_patterns,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              pat_we,
    input  logic [AW-1:0]     pat_addr,
    input  logic [31:0]       pat_data,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic [AW-1:0]     pat_idx
);

    localparam logic [1:0]  HT_IDLE   = 2'b00;
    localparam logic [1:0]  HT_NONSEQ = 2'b10;
    localparam logic [31:0] ADDR_DIR  = BASE_ADDR;
    localparam logic [31:0] ADDR_OUT  = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_IN   = BASE_ADDR + 32'h8;
    localparam logic [AW:0] DEPTH_N   = (AW+1)'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_DIR_A, S_DIR_D, S_OUT_A, S_OUT_D, S_IN_A, S_IN_D, S_HOLD, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       pat_mem [DEPTH];
    logic [31:0]       wdata;
    logic [31:0]       dir_lat;
    logic [AW:0]       cnt_lat;
    logic [HOLD_W-1:0] hold_lat;
    logic [HOLD_W-1:0] hold_cnt;
    logic              loop_lat;
    logic [AW:0]       num_clamped;
    logic              last_pat;

    assign num_clamped = (num_patterns > DEPTH_N) ? DEPTH_N : num_patterns;
    assign last_pat    = ({1'b0, pat_idx} == (cnt_lat - 1'b1));
    assign HSIZE       = 3'b010;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_DIR_A;
            S_DIR_A: if (abort) state_nxt = S_DONE;
                     else if (HREADY) state_nxt = S_DIR_D;
            S_DIR_D: if (HREADY) state_nxt = (cnt_lat != '0) ? S_OUT_A : S_DONE;
            S_OUT_A: if (abort) state_nxt = S_DONE;
                     else if (HREADY) state_nxt = S_OUT_D;
            S_OUT_D: if (HREADY) state_nxt = S_IN_A;
            S_IN_A:  if (HREADY) state_nxt = S_IN_D;
            S_IN_D:  if (HREADY) state_nxt = S_HOLD;
            S_HOLD:  if (abort) state_nxt = S_DONE;
                     else if (hold_cnt == '0)
                         state_nxt = (last_pat && !loop_lat) ? S_DONE : S_OUT_A;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address-phase states drop NONSEQ when abort is seen so no transfer is started.
    always_comb begin
        HADDR  = '0;
        HTRANS = HT_IDLE;
        HWRITE = 1'b0;
        HWDATA = '0;
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        case (state)
            S_DIR_A: begin
                HADDR  = ADDR_DIR;
                HWRITE = 1'b1;
                if (!abort) HTRANS = HT_NONSEQ;
            end
            S_DIR_D: begin
                HADDR  = ADDR_DIR;
                HWRITE = 1'b1;
                HWDATA = dir_lat;
            end
            S_OUT_A: begin
                HADDR  = ADDR_OUT;
                HWRITE = 1'b1;
                if (!abort) HTRANS = HT_NONSEQ;
            end
            S_OUT_D: begin
                HADDR  = ADDR_OUT;
                HWRITE = 1'b1;
                HWDATA = wdata;
            end
            S_IN_A: begin
                HADDR  = ADDR_IN;
                HTRANS = HT_NONSEQ;
            end
            S_IN_D:  HADDR = ADDR_IN;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pat_idx  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            cnt_lat  <= '0;
            hold_lat <= '0;
            hold_cnt <= '0;
            dir_lat  <= '0;
            loop_lat <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    cnt_lat  <= num_clamped;
                    hold_lat <= hold_cycles;
                    dir_lat  <= dir_value;
                    loop_lat <= loop_en;
                    pat_idx  <= '0;
                end
                S_IN_D: if (HREADY) begin
                    rd_data  <= HRDATA;
                    rd_valid <= 1'b1;
                    hold_cnt <= hold_lat;
                end
                S_HOLD: if (!abort) begin
                    if (hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;
                    else if (!last_pat)  pat_idx  <= pat_idx + 1'b1;
                    else if (loop_lat)   pat_idx  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Fetch reads before the same-edge table write lands, so a colliding write yields the old entry.
    always_ff @(posedge HCLK) begin
        if (pat_we)            pat_mem[pat_addr] <= pat_data;
        if (state == S_OUT_A)  wdata <= pat_mem[pat_idx];
    end

endmodule

// File: tb/tb_gpio_seq_master.sv
// Directed bench for gpio_seq_master: an AHB slave model with optional wait states and a
// transfer scoreboard fed by each step's expected bus traffic.
module tb_gpio_seq_master;

    localparam logic [31:0] BASE = 32'h4000_8000;

    logic        HCLK, HRESETn, start, abort, loop_en, pat_we, HREADY;
    logic [31:0] dir_value, pat_data, HADDR, HWDATA, HRDATA, rd_data;
    logic [4:0]  num_patterns;
    logic [15:0] hold_cycles;
    logic [3:0]  pat_addr, pat_idx;
    logic [1:0]  HTRANS;
    logic        HWRITE, busy, done, rd_valid;
    logic [2:0]  HSIZE;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] tab_m [16];
    int          checks = 0;
    int          errors = 0;
    int          rdv_total = 0;
    int          exp_idx [5] = '{0, 1, 2, 0, 1};

    logic        wait_mode = 1'b0;
    logic [1:0]  ws = '0;
    logic        dphase = 1'b0;
    logic [31:0] a_addr = '0;
    logic        a_write = 1'b0;
    logic [15:0] rdcnt = '0;
    logic        a_wait_prev = 1'b0, d_wait_prev = 1'b0, w_prev = 1'b0;
    logic [31:0] addr_prev = '0, wd_prev = '0;

    gpio_seq_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort), .loop_en(loop_en),
        .dir_value(dir_value), .num_patterns(num_patterns), .hold_cycles(hold_cycles),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .busy(busy), .done(done),
        .rd_valid(rd_valid), .rd_data(rd_data), .pat_idx(pat_idx)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    assign HREADY = !wait_mode || (ws == 2'd3);
    assign HRDATA = {16'hC0DE, rdcnt};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave side: tracks address/data phases and paces HREADY in wait-state mode.
    always @(posedge HCLK) begin
        if (!HRESETn) begin
            dphase <= 1'b0;
            ws     <= '0;
        end else begin
            if (wait_mode && (HTRANS == 2'b10 || dphase)) ws <= ws + 1'b1;
            if (HTRANS == 2'b10 && HREADY) begin
                dphase  <= 1'b1;
                a_addr  <= HADDR;
                a_write <= HWRITE;
            end else if (dphase && HREADY) begin
                dphase <= 1'b0;
                if (!a_write) rdcnt <= rdcnt + 1'b1;
            end
        end
    end

    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (dphase) begin
                chk("dphase_htrans", HTRANS, 2'b00);
                if (d_wait_prev && a_write) chk("hwdata_stable", HWDATA, wd_prev);
                if (HREADY) begin
                    chk("xfer_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        xfer_t e;
                        e = exp_q.pop_front();
                        chk("xfer_write", a_write, e.w);
                        chk("xfer_addr", a_addr, e.a);
                        if (e.w) chk("xfer_wdata", HWDATA, e.d);
                        else     rd_q.push_back(HRDATA);
                    end
                end
            end
            if (HTRANS == 2'b10) begin
                chk("hsize", HSIZE, 3'b010);
                if (a_wait_prev) begin
                    chk("haddr_stable", HADDR, addr_prev);
                    chk("hwrite_stable", HWRITE, w_prev);
                end
            end
            if (rd_valid) begin
                rdv_total++;
                chk("rd_avail", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) chk("rd_data", rd_data, rd_q.pop_front());
            end
            a_wait_prev = (HTRANS == 2'b10) && !HREADY;
            d_wait_prev = dphase && !HREADY;
            addr_prev   = HADDR;
            w_prev      = HWRITE;
            wd_prev     = HWDATA;
        end
    end

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{w: 1'b1, a: a, d: d});
    endtask

    task automatic push_r();
        exp_q.push_back('{w: 1'b0, a: BASE + 32'h8, d: 32'h0});
    endtask

    task automatic push_pat(input int i);
        push_w(BASE + 32'h4, tab_m[i]);
        push_r();
    endtask

    task automatic tab_wr(input int i, input logic [31:0] d);
        @(posedge HCLK); #1;
        pat_we = 1'b1; pat_addr = i[3:0]; pat_data = d; tab_m[i] = d;
        @(posedge HCLK); #1;
        pat_we = 1'b0;
    endtask

    task automatic kick(input logic [31:0] dir, input int n, input int hold, input logic lp);
        @(posedge HCLK); #1;
        dir_value = dir; num_patterns = n[4:0]; hold_cycles = hold[15:0]; loop_en = lp;
        start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int bcyc);
        bit seen;
        bcyc = 0;
        seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge HCLK);
            if (busy) bcyc++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        @(negedge HCLK);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    int  b, k, cnt, rdv0;
    bit  found;

    initial begin
        HRESETn = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0; pat_we = 1'b0;
        dir_value = '0; num_patterns = '0; hold_cycles = '0; pat_addr = '0; pat_data = '0;
        repeat (3) @(negedge HCLK);
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_hsize", HSIZE, 3'b010);
        chk("rst_bus", {HADDR, HWDATA}, 64'h0);
        chk("rst_ctrl", {HWRITE, busy, done, rd_valid}, 4'b0000);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_pat_idx", pat_idx, 4'h0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        for (int i = 0; i < 16; i++) tab_wr(i, 32'h1111_1111 * (i + 1));
        tab_wr(0, 32'hA5);
        tab_wr(1, 32'h5A);

        // Basic two-pattern run
        rdv0 = rdv_total;
        push_w(BASE, 32'hFF); push_pat(0); push_pat(1);
        kick(32'hFF, 2, 0, 1'b0);
        wait_done(100, b);
        chk("basic_busy_cycles", b, 13);
        chk("basic_rd_valid_pulses", rdv_total - rdv0, 2);
        chk("basic_pat_idx_end", pat_idx, 4'd1);
        chk("basic_queue_empty", exp_q.size(), 0);

        // Zero count: DIR write only
        push_w(BASE, 32'h3C);
        kick(32'h3C, 0, 0, 1'b0);
        wait_done(50, b);
        chk("zero_busy_cycles", b, 3);
        chk("zero_queue_empty", exp_q.size(), 0);

        // Start and abort together: no bus transfer
        abort = 1'b1;
        kick(32'h77, 2, 0, 1'b0);
        wait_done(50, b);
        abort = 1'b0;
        chk("startabort_busy_cycles", b, 2);

        // Wait states in every phase
        wait_mode = 1'b1;
        push_w(BASE, 32'h0F0F); push_pat(0); push_pat(1);
        kick(32'h0F0F, 2, 1, 1'b0);
        wait_done(200, b);
        chk("ws_busy_cycles", b, 45);
        chk("ws_queue_empty", exp_q.size(), 0);
        wait_mode = 1'b0;

        // Loop with abort in HOLD, plus a start pulse while busy
        push_w(BASE, 32'h0F);
        for (int i = 0; i < 5; i++) push_pat(i % 3);
        kick(32'h0F, 3, 5, 1'b1);
        k = 0;
        for (int i = 0; i < 200 && k < 5; i++) begin
            @(negedge HCLK);
            start = 1'b0;
            if (rd_valid) begin
                chk("loop_pat_idx", pat_idx, exp_idx[k][3:0]);
                k++;
                if (k == 2) start = 1'b1;
            end
        end
        start = 1'b0;
        chk("loop_reached_5", k, 5);
        abort = 1'b1;
        @(negedge HCLK);
        chk("abort_done_next", done, 1);
        abort = 1'b0;
        @(negedge HCLK);
        chk("abort_busy_low", busy, 0);
        chk("abort_pat_idx_kept", pat_idx, 4'd1);
        chk("loop_queue_empty", exp_q.size(), 0);

        // Hold of 10 gives 11 idle cycles before the next OUT address phase
        push_w(BASE, 32'hFF); push_pat(0); push_pat(1);
        kick(32'hFF, 2, 10, 1'b0);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge HCLK);
            if (rd_valid) begin found = 1; break; end
        end
        chk("hold_first_rd", found, 1);
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge HCLK);
            if (HTRANS == 2'b10) break;
            cnt++;
        end
        chk("hold_gap_cycles", cnt, 11);
        wait_done(100, b);
        chk("hold_queue_empty", exp_q.size(), 0);

        // Count above DEPTH clamps to 16 patterns
        push_w(BASE, 32'hAA);
        for (int i = 0; i < 16; i++) push_pat(i);
        kick(32'hAA, 20, 0, 1'b0);
        wait_done(300, b);
        chk("clamp_busy_cycles", b, 83);
        chk("clamp_pat_idx_end", pat_idx, 4'd15);
        chk("clamp_queue_empty", exp_q.size(), 0);

        // Asynchronous reset during OUT data phase
        push_w(BASE, 32'hFF); push_pat(0); push_pat(1);
        kick(32'hFF, 2, 0, 1'b0);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge HCLK);
            if (dphase && a_write && a_addr == BASE + 32'h4) begin found = 1; break; end
        end
        chk("reached_out_d", found, 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("async_htrans", HTRANS, 2'b00);
        chk("async_busy", busy, 0);
        chk("async_hwdata", HWDATA, 32'h0);
        exp_q.delete();
        rd_q.delete();
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        push_w(BASE, 32'hFF); push_pat(0);
        kick(32'hFF, 1, 0, 1'b0);
        wait_done(50, b);
        chk("post_reset_busy_cycles", b, 8);
        chk("post_reset_queue_empty", exp_q.size(), 0);

        repeat (3) @(negedge HCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_seq_master.md
Name: gpio_seq_master

Overview:
- AHB-Lite master that sequences the memory-mapped GPIO peripheral without CPU involvement.
- On start it writes the direction register, then steps through an internal pattern table. For each pattern it writes the output-data register, reads back the input register, and waits a programmable hold time.
- It sits on a master port of the AHB interconnect, alongside the Cortex-M3, with the GPIO slave as its only target.

Parameters:
- BASE_ADDR, 32'h4000_8000, GPIO base; DIR at +0x0, OUT at +0x4, IN at +0x8
- DEPTH, 16, pattern table entries
- AW, 4, table index width, equal to log2(DEPTH)
- HOLD_W, 16, width of the hold counter

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; starts a sequence when idle
- abort  in  1  level; ends the sequence at the next transfer boundary
- loop_en  in  1  1 = wrap to entry 0 after the last pattern
- dir_value  in  32  value written to the DIR register
- num_patterns  in  AW+1  patterns to play, 0..DEPTH; sampled at start
- hold_cycles  in  HOLD_W  idle cycles after each readback; sampled at start
- pat_we  in  1  table write strobe
- pat_addr  in  AW  table write index
- pat_data  in  32  table write data
- HADDR  out  32  AHB address
- HTRANS  out  2  AHB transfer type; only IDLE (00) or NONSEQ (10)
- HWRITE  out  1  AHB write
- HSIZE  out  3  fixed 3'b010 (word)
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB ready
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- rd_valid  out  1  one-cycle pulse; rd_data updated
- rd_data  out  32  last IN register value captured
- pat_idx  out  AW  index of the current pattern

Behaviour:
- Reset: clock is HCLK; reset is HRESETn, asynchronous and active-low.
  - All outputs are 0 except HSIZE, which is 010.
  - State returns to IDLE. Table contents are not reset.
- Table: synchronous write on pat_we, allowed in any state.
  - If pat_we hits the entry being fetched, the fetch returns the old value.
- Transfers are never pipelined.
  - Address phase: HTRANS=NONSEQ, with HADDR and HWRITE valid, held until a cycle where HREADY=1.
  - Data phase follows: HTRANS=IDLE; HWDATA is valid for writes and held until HREADY=1.
  - Reads capture HRDATA on the data-phase cycle where HREADY=1.
  - Minimum 2 cycles per transfer.
- FSM states: IDLE, DIR_A, DIR_D, OUT_A, OUT_D, IN_A, IN_D, HOLD, DONE.
- IDLE:
  - On start, latch num_patterns, hold_cycles, dir_value and loop_en.
  - Set busy=1 and pat_idx=0, then go to DIR_A.
- DIR_A → DIR_D: write dir_value to BASE+0x0.
  - Then go to OUT_A if the latched count is >0, else to DONE.
- OUT_A → OUT_D: write table[pat_idx] to BASE+0x4.
- IN_A → IN_D: read BASE+0x8.
  - On completion, rd_data ← HRDATA and rd_valid pulses for 1 cycle.
  - Then go to HOLD, loading the counter with hold_cycles.
- HOLD: decrement the counter each cycle. When it reaches 0, or immediately if loaded with 0:
  - If this was not the last pattern, increment pat_idx and go to OUT_A.
  - If it was the last pattern (pat_idx = count−1): with loop_en, wrap pat_idx to 0 and go to OUT_A; without it, go to DONE.
- DONE: done=1 for one cycle, busy=0, next state IDLE.
  - pat_idx keeps its last value until the next start.
- abort:
  - Sampled only in DIR_A (before HTRANS is asserted), OUT_A and HOLD.
  - If set, go to DONE. An in-flight data phase always completes.
  - abort while IDLE is ignored.
- start while busy is ignored.
  - start and abort together in IDLE: start wins. abort is then seen in DIR_A and ends the sequence with no bus transfer.
- num_patterns > DEPTH is clamped to DEPTH at latch.
- Per-pattern latency with HREADY=1 always: 4 + hold_cycles + 1 cycles (HOLD state counted once when hold=0).
- Reset mid-transfer: the bus returns to IDLE immediately; the slave must tolerate the abandoned transfer.

Test Plan:
- Basic: table {A5, 5A}, count=2, hold=0, dir=FF, HREADY=1.
  - Writes: 0x40008000←FF, 0x40008004←A5, read 0x40008008, write 0x40008004←5A, read 0x40008008.
  - rd_valid pulses twice; done pulses once; busy high for exactly 13 cycles.
- Zero count: count=0.
  - Only the DIR write occurs, then the done pulse; no OUT or IN transfers.
- Wait states: HREADY=0 for 3 cycles in each address and data phase.
  - HADDR, HTRANS, HWRITE and HWDATA are held stable throughout; no transfer is repeated or skipped.
- Loop and abort: loop_en=1, count=3, hold=5.
  - pat_idx sequence is 0,1,2,0,1,…
  - Raising abort during HOLD gives done in the following cycle; pulsing start while busy has no effect.
- Hold timing: hold=10.
  - 11 idle bus cycles between the IN data phase and the next OUT address phase.
- Async reset: assert HRESETn low during OUT_D.
  - HTRANS=00 and busy=0 without waiting for a clock edge; the next start runs cleanly from DIR.
